// File: rtl/sar_search_8bit_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_e;

  // Bit positions of the comparator flags inside the packed flag vector.
  localparam int unsigned FLAG_GT = 2;
  localparam int unsigned FLAG_LT = 1;
  localparam int unsigned FLAG_EQ = 0;
  localparam int unsigned FLAG_W  = 3;

endpackage

// File: rtl/sar_search_8bit_if.sv
// Handshake and comparator bundle between the SAR controller and its environment.
// slave: the controller side; master: the side that starts searches and answers compares.
interface sar_search_8bit_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] guess;
  logic             greater;
  logic             less;
  logic             equal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, greater, less, equal,
    input  guess, busy, done, result, err
  );

  modport slave (
    input  start, greater, less, equal,
    output guess, busy, done, result, err
  );

endinterface

// File: rtl/sar_search_8bit_flag_check.sv
// Combinational sanity check of the comparator flags: exactly one of
// greater/less/equal must be set. keep_bit says whether the trial bit survives.
module sar_flag_check
  import sar_pkg::*;
(
  input  logic i_greater,
  input  logic i_less,
  input  logic i_equal,
  output logic o_valid,
  output logic o_keep_bit
);

  logic [FLAG_W-1:0] w_flags;

  // Pack flags, then test for a single set bit and decode the keep decision.
  always_comb begin
    w_flags          = '0;
    w_flags[FLAG_GT] = i_greater;
    w_flags[FLAG_LT] = i_less;
    w_flags[FLAG_EQ] = i_equal;
    // Odd parity means one or three bits set; the AND term rejects three.
    o_valid          = (^w_flags) & ~(&w_flags);
    o_keep_bit       = w_flags[FLAG_LT] | w_flags[FLAG_EQ];
  end

endmodule

// File: rtl/sar_search_8bit.sv
// Successive-approximation search controller. Drives trial operands into an external
// magnitude comparator and binary-searches the comparator's other operand.
// Optional feature macro: SAR_EARLY_EXIT_EN (stop as soon as equal is reported).
module sar_search_8bit
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  sar_search_8bit_if.slave  bus
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_acc, w_acc_next;
  logic [IdxW-1:0]  r_idx, w_idx_next;
  logic [WIDTH-1:0] r_guess, w_guess_next;
  logic [WIDTH-1:0] r_result, w_result_next;
  logic             r_err, w_err_next;

  logic             w_valid;
  logic             w_keep_bit;
  logic [WIDTH-1:0] w_acc_step;
  logic [IdxW-1:0]  w_idx_step;

  sar_flag_check u_flag_check (
    .i_greater  (bus.greater),
    .i_less     (bus.less),
    .i_equal    (bus.equal),
    .o_valid    (w_valid),
    .o_keep_bit (w_keep_bit)
  );

  // State and datapath registers; reset clears every visible output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_idx    <= '0;
      r_guess  <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_acc    <= w_acc_next;
      r_idx    <= w_idx_next;
      r_guess  <= w_guess_next;
      r_result <= w_result_next;
      r_err    <= w_err_next;
    end
  end

  // Next-state and datapath update for one search step.
  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_idx_next    = r_idx;
    w_guess_next  = r_guess;
    w_result_next = r_result;
    w_err_next    = r_err;
    w_acc_step    = w_keep_bit ? r_guess : r_acc;
    w_idx_step    = r_idx - 1'b1;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = SEARCH;
          w_acc_next   = '0;
          w_idx_next   = IdxW'(WIDTH - 1);
          w_guess_next = WIDTH'(1) << (WIDTH - 1);
          w_err_next   = 1'b0;
        end
      end

      SEARCH: begin
        if (!w_valid) begin
          // Bad flags: report the last committed accumulator, not the trial.
          w_state_next  = DONE;
          w_err_next    = 1'b1;
          w_result_next = r_acc;
          w_guess_next  = '0;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (bus.equal) begin
          w_state_next  = DONE;
          w_result_next = r_guess;
          w_guess_next  = '0;
        end
`endif
        else begin
          w_acc_next = w_acc_step;
          if (r_idx == '0) begin
            w_state_next  = DONE;
            w_result_next = w_acc_step;
            w_guess_next  = '0;
          end else begin
            w_idx_next   = w_idx_step;
            w_guess_next = w_acc_step | (WIDTH'(1) << w_idx_step);
          end
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
        w_guess_next = '0;
      end
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    bus.guess  = r_guess;
    bus.busy   = (r_state == SEARCH);
    bus.done   = (r_state == DONE);
    bus.result = r_result;
    bus.err    = r_err;
  end

endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench for sar_search_8bit with a behavioural comparator in the loop.
module tb_sar_search_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] target;
  logic       force_bad;
  int         n_assert = 0;
  int         n_fail   = 0;

  logic [7:0] g_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [7:0] g_80 [8] = '{8'h80, 8'hC0, 8'hA0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h81};
  logic [7:0] g_00 [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] g_ff [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] g_3c [8] = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E, 8'h3D};

  sar_search_8bit_if #(.WIDTH(8)) intf ();

  sar_search_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  always #5 clk = ~clk;

  // Behavioural comparator, with an override that raises greater and less together.
  always_comb begin
    if (force_bad) begin
      intf.greater = 1'b1;
      intf.less    = 1'b1;
      intf.equal   = 1'b0;
    end else begin
      intf.greater = (intf.guess > target);
      intf.less    = (intf.guess < target);
      intf.equal   = (intf.guess == target);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full search from IDLE; checks the first n_chk guesses, latency and outputs.
  task automatic search(input string tag, input logic [7:0] tgt, input logic [7:0] exp_g [8],
                        input int n_chk, input int exp_lat, input logic [7:0] exp_res);
    int lat;
    target     = tgt;
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    check({tag, "_busy"}, intf.busy, 1'b1);
    check({tag, "_err_clr"}, intf.err, 1'b0);
    lat = 0;
    while (!intf.done && lat < 20) begin
      if (lat < n_chk) check($sformatf("%s_guess%0d", tag, lat), intf.guess, exp_g[lat]);
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, intf.result, exp_res);
    check({tag, "_err"}, intf.err, 1'b0);
    check({tag, "_busy_done"}, intf.busy, 1'b0);
    check({tag, "_guess_done"}, intf.guess, 8'h00);
    tick();
    check({tag, "_done_pulse"}, intf.done, 1'b0);
  endtask

  initial begin
    int lat;
    int n_done;
    rst_n      = 1'b0;
    intf.start = 1'b0;
    target     = 8'h00;
    force_bad  = 1'b0;
    #12;
    check("rst_guess", intf.guess, 8'h00);
    check("rst_busy", intf.busy, 1'b0);
    check("rst_done", intf.done, 1'b0);
    check("rst_result", intf.result, 8'h00);
    check("rst_err", intf.err, 1'b0);
    rst_n = 1'b1;
    tick();

    search("a5", 8'hA5, g_a5, 8, 8, 8'hA5);
`ifdef SAR_EARLY_EXIT_EN
    search("t80", 8'h80, g_80, 1, 1, 8'h80);
`else
    search("t80", 8'h80, g_80, 8, 8, 8'h80);
`endif
    search("t00", 8'h00, g_00, 8, 8, 8'h00);
    search("tff", 8'hFF, g_ff, 8, 8, 8'hFF);

    // Bad flags on the B0 trial: the committed accumulator at that point is A0.
    target     = 8'hA5;
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    tick();
    tick();
    tick();
    check("bad_guess", intf.guess, 8'hB0);
    force_bad = 1'b1;
    tick();
    force_bad = 1'b0;
    check("bad_done", intf.done, 1'b1);
    check("bad_err", intf.err, 1'b1);
    check("bad_result", intf.result, 8'hA0);
    check("bad_busy", intf.busy, 1'b0);
    tick();
    check("bad_done_pulse", intf.done, 1'b0);
    check("bad_err_held", intf.err, 1'b1);
    check("bad_result_held", intf.result, 8'hA0);
    search("a5_again", 8'hA5, g_a5, 8, 8, 8'hA5);

    // Reset during the fourth compare.
    target     = 8'hA5;
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_guess", intf.guess, 8'hB0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_guess", intf.guess, 8'h00);
    check("mid_rst_busy", intf.busy, 1'b0);
    check("mid_rst_result", intf.result, 8'h00);
    check("mid_rst_err", intf.err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", intf.done, 1'b0);
    end
    #3;
    rst_n = 1'b1;
    tick();
`ifdef SAR_EARLY_EXIT_EN
    search("t3c", 8'h3C, g_3c, 6, 6, 8'h3C);
`else
    search("t3c", 8'h3C, g_3c, 8, 8, 8'h3C);
`endif

    // Start pulsed mid-search must neither disturb nor queue a search.
    target     = 8'h5B;
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    tick();
    tick();
    intf.start = 1'b1;
    tick();
    intf.start = 1'b0;
    lat = 3;
    while (!intf.done && lat < 20) begin
      tick();
      lat++;
    end
    check("pulse_latency", lat, 8);
    check("pulse_result", intf.result, 8'h5B);
    tick();
    check("pulse_idle0", intf.busy, 1'b0);
    tick();
    check("pulse_idle1", intf.busy, 1'b0);

    // Start held high: one done every ten cycles.
    intf.start = 1'b1;
    tick();
    n_done = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (intf.done) begin
        check("b2b_spacing", c, 8 + 10 * n_done);
        check("b2b_result", intf.result, 8'h5B);
        n_done++;
      end
    end
    check("b2b_count", n_done, 3);
    intf.start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    check("b2b_idle", intf.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
